// File: rtl/pdm_dac.sv
// First-order delta-sigma DAC: codes arrive over valid/ready, are applied on
// fixed frame boundaries, and drive a registered 1-bit pulse-density output.
module pdm_dac #(
   parameter int unsigned p_bit_cnt   = 8,
   parameter int unsigned p_frame_len = 256
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic [p_bit_cnt-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic [p_bit_cnt-1:0] o_code,
   output logic                 o_frame,
   output logic                 o_underrun,
   output logic                 o_dac
);

   localparam int unsigned cnt_w = (p_frame_len > 1) ? $clog2(p_frame_len) : 1;
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(p_frame_len - 1);

   logic [p_bit_cnt-1:0] pending;
   logic                 pending_empty;
   logic [p_bit_cnt-1:0] r_code;
   logic [p_bit_cnt-1:0] acc;
   logic [cnt_w-1:0]     cnt;
   logic                 dac;
   logic                 frame;
   logic                 underrun;

   logic                 accept;
   logic                 cnt_wrap;
   logic                 boundary;
   logic [p_bit_cnt:0]   acc_sum;

   assign accept   = i_valid & pending_empty;
   assign cnt_wrap = (cnt == cnt_last);
   assign boundary = i_enable & cnt_wrap;
   assign acc_sum  = {1'b0, acc} + {1'b0, r_code};

   // One-entry input buffer; words only reach r_code on a frame boundary.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pending       <= '0;
         pending_empty <= 1'b1;
         r_code        <= '0;
      end else if (boundary && !pending_empty) begin
         r_code        <= pending;
         pending_empty <= 1'b1;
      end else if (accept) begin
         pending       <= i_data;
         pending_empty <= 1'b0;
      end
   end

   // Modulator and frame counter; accumulator carries across frames.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc      <= '0;
         cnt      <= '0;
         dac      <= 1'b0;
         frame    <= 1'b0;
         underrun <= 1'b0;
      end else if (i_enable) begin
         acc      <= acc_sum[p_bit_cnt-1:0];
         dac      <= acc_sum[p_bit_cnt];
         cnt      <= cnt_wrap ? '0 : cnt + cnt_w'(1);
         frame    <= cnt_wrap;
         underrun <= cnt_wrap & pending_empty;
      end else begin
         dac      <= 1'b0;
         frame    <= 1'b0;
         underrun <= 1'b0;
      end
   end

   assign o_ready    = pending_empty;
   assign o_code     = r_code;
   assign o_frame    = frame;
   assign o_underrun = underrun;
   assign o_dac      = dac;

endmodule

// File: tb/tb_pdm_dac.sv
// Self-checking bench for pdm_dac: table-driven code sequence plus
// hand-written enable-gap and mid-frame reset sequences, with a frame scoreboard.
module tb_pdm_dac;

   localparam int unsigned bit_cnt   = 8;
   localparam int unsigned frame_len = 256;

   logic               clk = 1'b0;
   logic               i_reset;
   logic               i_enable;
   logic [bit_cnt-1:0] i_data;
   logic               i_valid;
   logic               o_ready;
   logic [bit_cnt-1:0] o_code;
   logic               o_frame;
   logic               o_underrun;
   logic               o_dac;

   pdm_dac #(.p_bit_cnt(bit_cnt), .p_frame_len(frame_len)) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_enable   (i_enable),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .o_code     (o_code),
      .o_frame    (o_frame),
      .o_underrun (o_underrun),
      .o_dac      (o_dac)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [bit_cnt-1:0] code;
      int                 ones;
   } vec_t;

   vec_t vecs[7];
   vec_t sb[$];
   vec_t cur;
   int   passed = 0;
   int   total = 0;
   int   nframes = 0;
   int   ecnt = 0;
   int   running = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Advance one clock and check everything observable at the falling edge.
   task automatic cyc();
      vec_t e;
      int   ones;
      @(negedge clk);
      if (i_reset) begin
         sb.delete();
         cur.code = '0;
         cur.ones = 0;
         ecnt     = 0;
         running  = 0;
         nframes  = 0;
      end else begin
         if (i_enable) ecnt++;
         else chk("gap_dac_low", int'(o_dac), 0);
         if (o_frame) begin
            ones = running + int'(o_dac);
            chk("frame_ones", ones, cur.ones);
            chk("frame_enabled_len", ecnt, frame_len);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("frame_code_load", int'(o_code), int'(e.code));
               chk("frame_no_underrun", int'(o_underrun), 0);
               chk("ready_rise", int'(o_ready), 1);
               cur = e;
            end else begin
               chk("frame_code_held", int'(o_code), int'(cur.code));
               chk("frame_underrun", int'(o_underrun), 1);
            end
            ecnt    = 0;
            running = 0;
            nframes++;
         end else begin
            chk("underrun_only_on_frame", int'(o_underrun), 0);
            running += int'(o_dac);
         end
      end
   endtask

   task automatic push(input logic [bit_cnt-1:0] code, input int ones);
      logic was_ready;
      bit   done;
      vec_t e;
      done    = 1'b0;
      i_data  = code;
      i_valid = 1'b1;
      for (int i = 0; i < 2000 && !done; i++) begin
         was_ready = o_ready;
         cyc();
         if (was_ready) done = 1'b1;
      end
      i_valid = 1'b0;
      if (!done) begin
         chk("push_timeout", 0, 1);
      end else begin
         e.code = code;
         e.ones = ones;
         sb.push_back(e);
         chk("ready_fall", int'(o_ready), 0);
      end
   endtask

   task automatic wait_frames(input int n);
      for (int i = 0; i < 4000 && nframes < n; i++) cyc();
      if (nframes < n) chk("wait_frames_timeout", nframes, n);
   endtask

   task automatic check_reset_outputs();
      chk("rst_ready", int'(o_ready), 1);
      chk("rst_code", int'(o_code), 0);
      chk("rst_dac", int'(o_dac), 0);
      chk("rst_frame", int'(o_frame), 0);
      chk("rst_underrun", int'(o_underrun), 0);
   endtask

   initial begin
      int n0;
      int cycles;
      bit seen;

      vecs[0] = '{code: 8'h40, ones: 64};
      vecs[1] = '{code: 8'h10, ones: 16};
      vecs[2] = '{code: 8'h20, ones: 32};
      vecs[3] = '{code: 8'h00, ones: 0};
      vecs[4] = '{code: 8'hFF, ones: 255};
      vecs[5] = '{code: 8'hC3, ones: 195};
      vecs[6] = '{code: 8'h80, ones: 128};

      i_reset  = 1'b1;
      i_enable = 1'b0;
      i_valid  = 1'b0;
      i_data   = '0;
      cyc();
      cyc();
      check_reset_outputs();
      i_reset  = 1'b0;
      i_enable = 1'b1;

      // Each code modulated for one frame; the last is followed by two underruns.
      for (int i = 0; i < 7; i++) push(vecs[i].code, vecs[i].ones);
      wait_frames(9);

      // Enable gap of 37 cycles mid-frame with code 0x40.
      push(8'h40, 64);
      wait_frames(10);
      for (int i = 0; i < 50; i++) cyc();
      i_enable = 1'b0;
      for (int i = 0; i < 37; i++) cyc();
      i_enable = 1'b1;
      cycles = 87;
      n0     = nframes;
      seen   = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         cyc();
         cycles++;
         if (nframes > n0) seen = 1'b1;
      end
      chk("gap_frame_delay", cycles, frame_len + 37);

      // Reset at counter 100 with the pending buffer full.
      push(8'h55, 85);
      for (int i = 0; i < 1000 && ecnt != 100; i++) cyc();
      chk("reached_counter_100", ecnt, 100);
      i_reset = 1'b1;
      cyc();
      check_reset_outputs();
      i_reset = 1'b0;
      cycles  = 0;
      for (int i = 0; i < 1000 && nframes < 1; i++) begin
         cyc();
         cycles++;
      end
      chk("post_reset_frame_delay", cycles, frame_len);
      chk("post_reset_code", int'(o_code), 0);
      chk("post_reset_ready", int'(o_ready), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
